// File: rtl/altivec_vsfx_top_if.sv
// Issue/result bundle for the AltiVec vector simple fixed-point unit.
// The master drives the operation; the slave (the VSFX unit) returns the registered result.
interface altivec_vsfx_top_if;
  logic         en;
  logic [127:0] vra;
  logic [127:0] vrb;
  logic [7:0]   ins;
  logic [127:0] vrt;
  logic         vrt_en;
  logic         sat;
  logic [3:0]   cr6;

  modport master (output en, vra, vrb, ins, input vrt, vrt_en, sat, cr6);
  modport slave  (input en, vra, vrb, ins, output vrt, vrt_en, sat, cr6);
endinterface

// File: rtl/altivec_vsfx_top.sv
// AltiVec VSFX: lane-wise add/sub/min/max/compare and 128-bit logicals, one-cycle latency.
// Optional macro VSFX_SAT_STICKY_EN makes sat a sticky VSCR[SAT]-style flag cleared only by rst.
module altivec_vsfx_top (
  input logic            clk,
  input logic            rst,
  altivec_vsfx_top_if.slave bus
);

  typedef struct packed {
    logic [31:0] r;
    logic        sat;
    logic        t;
  } lane_res_t;

  // One lane of width n (8/16/32); operands arrive zero-extended to 32 bits.
  // 34-bit signed arithmetic holds every intermediate sum/difference without overflow.
  function automatic lane_res_t lane_op(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [5:0] n);
    logic signed [33:0] ua, ub, sa, sb, umax, smax, smin, x;
    logic [4:0]         msb;
    lane_res_t          lr;
    msb  = 5'(n - 6'd1);
    umax = (34'sd1 <<< n) - 34'sd1;
    smax = (34'sd1 <<< msb) - 34'sd1;
    smin = -(34'sd1 <<< msb);
    ua   = {2'b00, a};
    ub   = {2'b00, b};
    sa   = a[msb] ? ua - (34'sd1 <<< n) : ua;
    sb   = b[msb] ? ub - (34'sd1 <<< n) : ub;
    lr   = '0;
    x    = '0;
    case (op)
      4'h0: x = ua + ub;
      4'h1: begin x = ua + ub; if (x > umax) begin x = umax; lr.sat = 1'b1; end end
      4'h2: begin
        x = sa + sb;
        if (x > smax) begin x = smax; lr.sat = 1'b1; end
        else if (x < smin) begin x = smin; lr.sat = 1'b1; end
      end
      4'h3: x = ua - ub;
      4'h4: begin x = ua - ub; if (x < 0) begin x = '0; lr.sat = 1'b1; end end
      4'h5: begin
        x = sa - sb;
        if (x > smax) begin x = smax; lr.sat = 1'b1; end
        else if (x < smin) begin x = smin; lr.sat = 1'b1; end
      end
      4'h6: x = (ua > ub) ? ua : ub;
      4'h7: lr.t = (ua == ub);
      4'h8: lr.t = (ua > ub);
      4'h9: lr.t = (sa > sb);
      4'hA: x = (ua < ub) ? ua : ub;
      4'hB: x = (sa > sb) ? sa : sb;
      4'hC: x = (sa < sb) ? sa : sb;
      default: x = '0;
    endcase
    if (lr.t) x = umax;
    lr.r = x[31:0] & umax[31:0];
    return lr;
  endfunction

  logic [3:0]   op;
  logic [1:0]   size;
  logic [127:0] res;
  logic         any_sat, all_t, all_f, valid, is_cmp;
  logic [3:0]   cr6_nxt;
  lane_res_t    lr;
  logic         unused_rsvd;

  assign op          = bus.ins[7:4];
  assign size        = bus.ins[3:2];
  assign unused_rsvd = bus.ins[0];
  assign is_cmp      = (op == 4'h7) || (op == 4'h8) || (op == 4'h9);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    res     = '0;
    any_sat = 1'b0;
    all_t   = 1'b1;
    all_f   = 1'b1;
    valid   = 1'b1;
    lr      = '0;
    if (op >= 4'hD) begin
      case (op)
        4'hD:    res = bus.vra & bus.vrb;
        4'hE:    res = bus.vra | bus.vrb;
        default: res = bus.vra ^ bus.vrb;
      endcase
    end else begin
      case (size)
        2'b00:
          for (int i = 0; i < 16; i++) begin
            lr = lane_op(op, {24'h0, bus.vra[i*8 +: 8]}, {24'h0, bus.vrb[i*8 +: 8]}, 6'd8);
            res[i*8 +: 8] = lr.r[7:0];
            any_sat |= lr.sat;
            all_t   &= lr.t;
            all_f   &= ~lr.t;
          end
        2'b01:
          for (int i = 0; i < 8; i++) begin
            lr = lane_op(op, {16'h0, bus.vra[i*16 +: 16]}, {16'h0, bus.vrb[i*16 +: 16]}, 6'd16);
            res[i*16 +: 16] = lr.r[15:0];
            any_sat |= lr.sat;
            all_t   &= lr.t;
            all_f   &= ~lr.t;
          end
        2'b10:
          for (int i = 0; i < 4; i++) begin
            lr = lane_op(op, bus.vra[i*32 +: 32], bus.vrb[i*32 +: 32], 6'd32);
            res[i*32 +: 32] = lr.r;
            any_sat |= lr.sat;
            all_t   &= lr.t;
            all_f   &= ~lr.t;
          end
        default: valid = 1'b0;
      endcase
    end
    cr6_nxt = (valid && is_cmp && bus.ins[1]) ? {all_t, 1'b0, all_f, 1'b0} : 4'b0000;
  end

  // NOTE: registered state uses non-blocking assignments so all outputs update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vrt    <= '0;
      bus.vrt_en <= 1'b0;
      bus.sat    <= 1'b0;
      bus.cr6    <= '0;
    end else begin
      bus.vrt_en <= bus.en & valid;
      if (bus.en) begin
        // res, any_sat and cr6_nxt are already zero for a reserved-size op.
        bus.vrt <= res;
        bus.cr6 <= cr6_nxt;
`ifdef VSFX_SAT_STICKY_EN
        bus.sat <= bus.sat | any_sat;
`else
        bus.sat <= any_sat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_altivec_vsfx_top.sv
// Self-checking bench for altivec_vsfx_top: directed test-plan vectors plus randomized ops
// against an integer-arithmetic reference model.
module tb_altivec_vsfx_top;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [127:0] exp_vrt = '0;
  logic         exp_en  = 1'b0;
  logic         exp_sat = 1'b0;
  logic [3:0]   exp_cr6 = '0;

  altivec_vsfx_top_if ifc ();
  altivec_vsfx_top dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: each lane taken as an integer, the rule applied with plain arithmetic.
  function automatic void model(input logic [7:0] i, input logic [127:0] a, input logic [127:0] b,
                                output logic [127:0] r, output logic v, output logic s,
                                output logic [3:0] c);
    int          op, n, lanes;
    longint      ua, ub, sa, sb, x, umax, smax, smin, full;
    logic [127:0] ta, tb;
    bit          t, all_t, all_f, cmp;
    op = int'(i[7:4]);
    r = '0; v = 1'b1; s = 1'b0; c = 4'b0000;
    if (op == 13) begin r = a & b; return; end
    if (op == 14) begin r = a | b; return; end
    if (op == 15) begin r = a ^ b; return; end
    if (i[3:2] == 2'b11) begin v = 1'b0; return; end
    n     = 8 << i[3:2];
    lanes = 128 / n;
    full  = longint'(1) << n;
    umax  = full - 1;
    smax  = (full / 2) - 1;
    smin  = -(full / 2);
    cmp   = (op >= 7 && op <= 9);
    all_t = 1; all_f = 1;
    for (int k = 0; k < lanes; k++) begin
      ta = a >> (k * n);
      tb = b >> (k * n);
      ua = longint'(ta[31:0]) & umax;
      ub = longint'(tb[31:0]) & umax;
      sa = (ua > smax) ? ua - full : ua;
      sb = (ub > smax) ? ub - full : ub;
      t  = 0;
      case (op)
        0: x = ua + ub;
        1: begin x = ua + ub; if (x > umax) begin x = umax; s = 1; end end
        2: begin x = sa + sb; if (x > smax) begin x = smax; s = 1; end
                             else if (x < smin) begin x = smin; s = 1; end end
        3: x = ua - ub;
        4: begin x = ua - ub; if (x < 0) begin x = 0; s = 1; end end
        5: begin x = sa - sb; if (x > smax) begin x = smax; s = 1; end
                             else if (x < smin) begin x = smin; s = 1; end end
        6: x = (ua > ub) ? ua : ub;
        7: t = (ua == ub);
        8: t = (ua > ub);
        9: t = (sa > sb);
        10: x = (ua < ub) ? ua : ub;
        11: x = (sa > sb) ? sa : sb;
        default: x = (sa < sb) ? sa : sb;
      endcase
      if (cmp) x = t ? umax : 0;
      x = x & umax;
      r = r | (128'(x) << (k * n));
      all_t = all_t & t;
      all_f = all_f & !t;
    end
    if (cmp && i[1]) c = {all_t, 1'b0, all_f, 1'b0};
  endfunction

  // One cycle: drive on the falling edge, update the model at the rising edge, sample 1ns later.
  task automatic step(input logic r, input logic e, input logic [7:0] i,
                      input logic [127:0] a, input logic [127:0] b);
    logic [127:0] m_r;
    logic         m_v, m_s;
    logic [3:0]   m_c;
    @(negedge clk);
    rst = r; ifc.en = e; ifc.ins = i; ifc.vra = a; ifc.vrb = b;
    @(posedge clk);
    if (r) begin
      exp_vrt = '0; exp_en = 1'b0; exp_sat = 1'b0; exp_cr6 = '0;
    end else if (e) begin
      model(i, a, b, m_r, m_v, m_s, m_c);
      exp_en  = m_v;
      exp_vrt = m_r;
      exp_cr6 = m_c;
`ifdef VSFX_SAT_STICKY_EN
      exp_sat = exp_sat | m_s;
`else
      exp_sat = m_s;
`endif
    end else begin
      exp_en = 1'b0;
    end
    #1;
    check("vrt",    ifc.vrt,    exp_vrt);
    check("vrt_en", 128'(ifc.vrt_en), 128'(exp_en));
    check("sat",    128'(ifc.sat),    128'(exp_sat));
    check("cr6",    128'(ifc.cr6),    128'(exp_cr6));
  endtask

  function automatic logic [127:0] rand_vec(input int mode);
    logic [127:0] v;
    logic [7:0]   pick [5];
    pick[0] = 8'h00; pick[1] = 8'h7F; pick[2] = 8'h80; pick[3] = 8'hFF; pick[4] = 8'h01;
    v = {$urandom, $urandom, $urandom, $urandom};
    if (mode == 3)
      for (int k = 0; k < 16; k++) v[k*8 +: 8] = pick[$urandom_range(0, 4)];
    return v;
  endfunction

  initial begin
    logic [127:0] a, b;
    logic [7:0]   i;
    int           mode;
    rst = 1'b1; ifc.en = 1'b0; ifc.ins = '0; ifc.vra = '0; ifc.vrb = '0;

    step(1'b1, 1'b0, 8'h00, '0, '0);
    check("reset_vrt", ifc.vrt, 128'h0);

    step(1'b0, 1'b1, 8'h70, '0, 128'hffffffff00000000ffffffff00000000);
    check("tp_cmpeq_b", ifc.vrt, 128'h00000000ffffffff00000000ffffffff);
    step(1'b0, 1'b1, 8'h7A, 128'h1, 128'h1);
    check("tp_cmpeq_w_all", ifc.vrt, {128{1'b1}});
    check("tp_cr6_all", 128'(ifc.cr6), 128'(4'b1000));
    step(1'b0, 1'b1, 8'h7A, 128'h1, ~128'h1);
    check("tp_cr6_none", 128'(ifc.cr6), 128'(4'b0010));
    step(1'b0, 1'b1, 8'h10, {16{8'hF0}}, {16{8'h20}});
    check("tp_addus_b", ifc.vrt, {16{8'hFF}});
    step(1'b0, 1'b1, 8'h00, {16{8'hF0}}, {16{8'h20}});
    check("tp_addmod_b", ifc.vrt, {16{8'h10}});
    step(1'b0, 1'b1, 8'h54, {8{16'h8000}}, {8{16'h0001}});
    check("tp_subss_h_sat", ifc.vrt, {8{16'h8000}});
    step(1'b0, 1'b1, 8'h54, {8{16'h0005}}, {8{16'h0003}});
    check("tp_subss_h", ifc.vrt, {8{16'h0002}});
    step(1'b0, 1'b0, 8'h00, '0, '0);
    check("tp_hold_vrt", ifc.vrt, {8{16'h0002}});
    step(1'b0, 1'b1, 8'h0C, {16{8'h11}}, {16{8'h22}});
    check("tp_rsvd_size_en", 128'(ifc.vrt_en), 128'(1'b0));
    step(1'b0, 1'b1, 8'hFC, {32{4'hA}}, {32{4'hF}});
    check("tp_xor_rsvd_size", ifc.vrt, {32{4'h5}});
    step(1'b0, 1'b1, 8'hC8, {4{32'hFFFFFFFF}}, {4{32'h00000001}});
    check("tp_minsw", ifc.vrt, {4{32'hFFFFFFFF}});
    step(1'b1, 1'b1, 8'h10, {16{8'hF0}}, {16{8'h20}});
    check("tp_rst_over_en", ifc.vrt, 128'h0);

    for (int n = 0; n < 400; n++) begin
      mode = $urandom_range(0, 3);
      a = rand_vec(mode);
      case (mode)
        0:       b = a;
        1:       b = rand_vec(1);
        2:       b = a ^ (128'(1) << $urandom_range(0, 127));
        default: b = rand_vec(3);
      endcase
      i = 8'($urandom);
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85, i, a, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
